// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: controller state encodings and stall-vector constants.
// Stall vector bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EX_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: freezes stages for load-use / multi-cycle EX and redirects on branches.
// Latency: stall/flush/new_pc are combinational from state and requests (same-cycle effect).
// Backpressure: none accepted; ex_busy waits are bounded by TIMEOUT, flushes ignore all requests.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_req,
    input  logic        ex_busy_req,
    input  logic        ex_done,
    input  logic        br_flush_req,
    input  logic [31:0] br_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout_err,
    output logic [31:0] stall_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    // wait_cnt holds (EX_WAIT cycles elapsed - 1); release on the cycle it would reach TIMEOUT-1
    localparam logic [WW-1:0] WAIT_LAST  = WW'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);
    localparam logic [3:0]    FLUSH_LOAD = 4'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    flush_cnt;
    logic [31:0]   tgt;
    logic          timeout_fire;

    assign timeout_fire = (state == ST_EX_WAIT) && !ex_done && (wait_cnt >= WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (br_flush_req) begin
                    state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (ex_busy_req) begin
                    state_nxt = ST_EX_WAIT;
                end
            end
            ST_EX_WAIT: begin
                if (ex_done || timeout_fire) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Outputs are gated by reset so nothing leaks out while rst is low, whatever the requests.
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'd0;
        if (rst) begin
            case (state)
                ST_RUN: begin
                    if (br_flush_req) begin
                        flush  = 1'b1;
                        new_pc = br_target;
                    end else if (ex_busy_req) begin
                        stall = STALL_EX;
                    end else if (id_stall_req) begin
                        stall = STALL_ID;
                    end
                end
                ST_EX_WAIT: begin
                    if (!ex_done && !timeout_fire) begin
                        stall = STALL_EX;
                    end
                end
                ST_FLUSH: begin
                    flush  = 1'b1;
                    new_pc = tgt;
                end
                default: stall = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            flush_cnt   <= 4'd0;
            tgt         <= 32'd0;
            timeout_err <= 1'b0;
            stall_cnt   <= 32'd0;
        end else begin
            if (state == ST_RUN && br_flush_req) begin
                tgt       <= br_target;
                flush_cnt <= FLUSH_LOAD;
            end else if (state == ST_FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end

            if (state == ST_RUN && !br_flush_req && ex_busy_req) begin
                wait_cnt <= '0;
            end else if (state == ST_EX_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (timeout_fire) begin
                timeout_err <= 1'b1;
            end

            if (stall[0] && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
// Two instances run side by side: a = (TIMEOUT 8, FLUSH_CYCLES 3), b = defaults (64, 1).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        ex_busy_req = 1'b0;
    logic        ex_done = 1'b0;
    logic        br_flush_req = 1'b0;
    logic [31:0] br_target = 32'd0;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        terr_a, terr_b;
    logic [31:0] stall_cnt_a, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(8), .FLUSH_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst),
        .id_stall_req(id_stall_req), .ex_busy_req(ex_busy_req), .ex_done(ex_done),
        .br_flush_req(br_flush_req), .br_target(br_target),
        .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
        .timeout_err(terr_a), .stall_cnt(stall_cnt_a)
    );

    pipeline_ctrl dut_b (
        .clk(clk), .rst(rst),
        .id_stall_req(id_stall_req), .ex_busy_req(ex_busy_req), .ex_done(ex_done),
        .br_flush_req(br_flush_req), .br_target(br_target),
        .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
        .timeout_err(terr_b), .stall_cnt(stall_cnt_b)
    );

    // Reference model: tracks "how long have we been stalled" and "how many flush cycles remain".
    typedef struct {
        bit          waiting;
        int          waited;
        int          flush_left;
        logic [31:0] tgt;
        bit          terr;
        logic [31:0] scnt;
    } mdl_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    mdl_t ma, mb, na, nb;
    exp_t ea, eb;

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m.waiting    = 1'b0;
        m.waited     = 0;
        m.flush_left = 0;
        m.tgt        = 32'd0;
        m.terr       = 1'b0;
        m.scnt       = 32'd0;
        return m;
    endfunction

    function automatic void model_step(input mdl_t cur, input int tmo, input int fc,
                                       output mdl_t nxt, output exp_t e);
        nxt     = cur;
        e.stall = 6'b000000;
        e.flush = 1'b0;
        e.pc    = 32'd0;
        if (cur.flush_left > 0) begin
            e.flush        = 1'b1;
            e.pc           = cur.tgt;
            nxt.flush_left = cur.flush_left - 1;
        end else if (cur.waiting) begin
            if (ex_done) begin
                nxt.waiting = 1'b0;
            end else if (cur.waited >= tmo - 1) begin
                nxt.waiting = 1'b0;
                nxt.terr    = 1'b1;
            end else begin
                e.stall    = 6'b001111;
                nxt.waited = cur.waited + 1;
            end
        end else if (br_flush_req) begin
            e.flush        = 1'b1;
            e.pc           = br_target;
            nxt.tgt        = br_target;
            nxt.flush_left = fc - 1;
        end else if (ex_busy_req) begin
            e.stall     = 6'b001111;
            nxt.waiting = 1'b1;
            nxt.waited  = 1;
        end else if (id_stall_req) begin
            e.stall = 6'b000111;
        end
        if (e.stall[0] && cur.scnt != 32'hFFFF_FFFF) nxt.scnt = cur.scnt + 32'd1;
    endfunction

    task automatic clear_inputs();
        id_stall_req = 1'b0;
        ex_busy_req  = 1'b0;
        ex_done      = 1'b0;
        br_flush_req = 1'b0;
        br_target    = 32'd0;
    endtask

    // Leaves the bench just after a rising edge with reset released and inputs idle.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ma = mdl_zero();
        mb = mdl_zero();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst          = 1'b0;
        id_stall_req = 1'b1;
        ex_busy_req  = 1'b1;
        ex_done      = 1'b1;
        br_flush_req = 1'b1;
        br_target    = 32'hCAFE_0004;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (stall_a !== 6'b0 || stall_b !== 6'b0 || flush_a !== 1'b0 || flush_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: stall %b/%b flush %b/%b, required 0", c, stall_a, stall_b, flush_a, flush_b);
            end
            checks++;
            if (stall_cnt_a !== 32'd0 || stall_cnt_b !== 32'd0 || new_pc_a !== 32'd0 || terr_a !== 1'b0 || terr_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_regs cyc %0d: stall_cnt %0d/%0d new_pc %h terr %b/%b, required 0", c, stall_cnt_a, stall_cnt_b, new_pc_a, terr_a, terr_b);
            end
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        id_stall_req = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_a !== 6'b000111 || stall_b !== 6'b000111) begin
            errors++;
            $display("FAIL load_use_stall: got %b/%b, required 000111", stall_a, stall_b);
        end
        @(posedge clk); #1;
        id_stall_req = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_a !== 6'b0 || stall_cnt_a !== 32'd1 || stall_cnt_b !== 32'd1) begin
            errors++;
            $display("FAIL load_use_after: stall %b cnt %0d/%0d, required 0 and 1", stall_a, stall_cnt_a, stall_cnt_b);
        end
    endtask

    task automatic test_multicycle();
        logic [5:0] exp_s;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            ex_busy_req = (c == 0);
            ex_done     = (c == 5);
            exp_s       = (c < 5) ? 6'b001111 : 6'b000000;
            @(negedge clk);
            checks++;
            if (stall_a !== exp_s || stall_b !== exp_s) begin
                errors++;
                $display("FAIL multicycle_stall cyc %0d: got %b/%b, required %b", c, stall_a, stall_b, exp_s);
            end
            @(posedge clk); #1;
        end
        ex_done     = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_a !== 6'b0 || stall_cnt_a !== 32'd5 || stall_cnt_b !== 32'd5) begin
            errors++;
            $display("FAIL multicycle_count: stall %b cnt %0d/%0d, required 0 and 5", stall_a, stall_cnt_a, stall_cnt_b);
        end
        @(posedge clk); #1;
        ex_done = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        id_stall_req = 1'b1;
        ex_busy_req  = 1'b1;
        br_flush_req = 1'b1;
        br_target    = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (flush_a !== 1'b1 || flush_b !== 1'b1 || new_pc_a !== 32'h100 || new_pc_b !== 32'h100 ||
            stall_a !== 6'b0 || stall_b !== 6'b0) begin
            errors++;
            $display("FAIL simul_flush: flush %b/%b pc %h/%h stall %b/%b, required 1 100 0", flush_a, flush_b, new_pc_a, new_pc_b, stall_a, stall_b);
        end
        // a keeps flushing on the latched target; b (single-cycle flush) takes the new redirect
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            br_target = 32'hDEAD_BEE0;
            @(negedge clk);
            checks++;
            if (flush_a !== 1'b1 || new_pc_a !== 32'h100 || stall_a !== 6'b0) begin
                errors++;
                $display("FAIL long_flush_a cyc %0d: flush %b pc %h stall %b, required 1 100 0", c, flush_a, new_pc_a, stall_a);
            end
            checks++;
            if (flush_b !== 1'b1 || new_pc_b !== 32'hDEAD_BEE0 || stall_b !== 6'b0) begin
                errors++;
                $display("FAIL short_flush_b cyc %0d: flush %b pc %h stall %b, required 1 deadbee0 0", c, flush_b, new_pc_b, stall_b);
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (flush_a !== 1'b0 || flush_b !== 1'b0 || stall_a !== 6'b0 || stall_b !== 6'b0) begin
            errors++;
            $display("FAIL flush_end: flush %b/%b stall %b/%b, required 0", flush_a, flush_b, stall_a, stall_b);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ex_busy_req = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) ex_busy_req = 1'b0;
            @(negedge clk);
            checks++;
            if (stall_a !== ((c < 7) ? 6'b001111 : 6'b000000) || terr_a !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cyc %0d: stall %b terr %b", c, stall_a, terr_a);
            end
            @(posedge clk); #1;
        end
        for (int c = 8; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (terr_a !== 1'b1 || stall_a !== 6'b0 || stall_cnt_a !== 32'd7) begin
                errors++;
                $display("FAIL timeout_sticky cyc %0d: terr %b stall %b cnt %0d, required 1 0 7", c, terr_a, stall_a, stall_cnt_a);
            end
            checks++;
            if (stall_b !== 6'b001111 || terr_b !== 1'b0) begin
                errors++;
                $display("FAIL timeout_long_b cyc %0d: stall %b terr %b, required 001111 0", c, stall_b, terr_b);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        ex_busy_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (stall_a !== 6'b0 || stall_b !== 6'b0 || flush_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: stall %b/%b flush %b, required 0", stall_a, stall_b, flush_a);
        end
        @(posedge clk); #1;
        ex_busy_req  = 1'b0;
        rst          = 1'b1;
        id_stall_req = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_a !== 6'b000111 || stall_b !== 6'b000111) begin
            errors++;
            $display("FAIL reset_back_to_run: stall %b/%b, required 000111", stall_a, stall_b);
        end
        @(posedge clk); #1;
        id_stall_req = 1'b0;
        br_flush_req = 1'b1;
        br_target    = 32'h0000_0040;
        @(posedge clk); #1;
        br_flush_req = 1'b0;
        rst          = 1'b0;
        #1;
        checks++;
        if (flush_a !== 1'b0 || new_pc_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_flush: flush %b pc %h, required 0 0", flush_a, new_pc_a);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (flush_a !== 1'b0 || stall_a !== 6'b0) begin
            errors++;
            $display("FAIL reset_no_residue: flush %b stall %b, required 0", flush_a, stall_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            id_stall_req = ($urandom_range(0, 99) < 30);
            ex_busy_req  = ($urandom_range(0, 99) < 12);
            ex_done      = ($urandom_range(0, 99) < 15);
            br_flush_req = ($urandom_range(0, 99) < 10);
            br_target    = $urandom;
            model_step(ma, 8, 3, na, ea);
            model_step(mb, 64, 1, nb, eb);
            @(negedge clk);
            checks++;
            if ({stall_a, flush_a, new_pc_a, terr_a, stall_cnt_a} !== {ea.stall, ea.flush, ea.pc, ma.terr, ma.scnt}) begin
                errors++;
                $display("FAIL random_a cyc %0d: stall %b flush %b pc %h terr %b cnt %0d, required %b %b %h %b %0d",
                         c, stall_a, flush_a, new_pc_a, terr_a, stall_cnt_a, ea.stall, ea.flush, ea.pc, ma.terr, ma.scnt);
            end
            checks++;
            if ({stall_b, flush_b, new_pc_b, terr_b, stall_cnt_b} !== {eb.stall, eb.flush, eb.pc, mb.terr, mb.scnt}) begin
                errors++;
                $display("FAIL random_b cyc %0d: stall %b flush %b pc %h terr %b cnt %0d, required %b %b %h %b %0d",
                         c, stall_b, flush_b, new_pc_b, terr_b, stall_cnt_b, eb.stall, eb.flush, eb.pc, mb.terr, mb.scnt);
            end
            @(posedge clk); #1;
            ma = na;
            mb = nb;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_simultaneous();
        test_timeout();
        test_reset_midway();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
